// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic array controller.
// Optional feature macro: SKEW_GEN_EN (internal per-column input skew).
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int INT_BITS_DEF = 13;
  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int LEN_W_DEF    = 8;

  // Depth of the valid-tag delay line: long enough to cover the last column.
  function automatic int tag_depth(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_buf.sv
// skew_buf: fixed-depth delay line for one array input column.
// Depth 0 is a plain wire. Used only when SKEW_GEN_EN is defined.
module skew_buf #(
  parameter int W     = 13,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_dly
      logic [W-1:0] pipe [DEPTH];

      // Shift the column value down the delay line, cleared on reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= din;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dout = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, activation streaming and drain for
// a ROWS x COLS systolic array. With SKEW_GEN_EN defined, activation columns
// are skewed internally and out_valid is skewed per column; otherwise the
// caller supplies pre-skewed data.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_LOAD_W | accepting ROWS weight rows, bottom row first
// S_STREAM | accepting cfg_len activation vectors, bubbles when none
// S_DRAIN  | feeding zeros until the valid-tag line empties
// S_DONE   | one-cycle done pulse
module systolic_ctrl
  import sa_pkg::*;
#(
  parameter int int_bits = INT_BITS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [COLS*int_bits-1:0] wt_data,
  input  logic                     wt_valid,
  output logic                     wt_ready,
  input  logic [COLS*int_bits-1:0] act_data,
  input  logic                     act_valid,
  output logic                     act_ready,
  output logic [COLS*int_bits-1:0] array_in,
  output logic [ROWS-1:0]          weight_en,
  output logic                     array_rst,
  output logic [COLS-1:0]          out_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int TAG_D = tag_depth(ROWS, COLS);
  localparam int WB_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROWS-1:0] ROW_MSB = ROWS'(1) << (ROWS - 1);

  state_t                     state;
  logic [WB_W-1:0]            wbeat;
  logic [LEN_W-1:0]           vcnt;
  logic [LEN_W-1:0]           vcnt_nxt;
  logic [LEN_W-1:0]           len_q;
  logic [TAG_D-1:0]           tag_line;
  logic [COLS*int_bits-1:0]   ain_q;
  logic                       wsel_q;
  logic                       rst_q;

  // Saturating vector count; never wraps back to zero.
  assign vcnt_nxt = (vcnt == '1) ? vcnt : vcnt + 1'b1;

  // PE reset covers the reset period plus one cycle after release.
  always_ff @(posedge clk) begin
    rst_q     <= !reset;
    array_rst <= !reset | rst_q;
  end

  // Controller FSM with registered handshake and array-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      wbeat     <= '0;
      vcnt      <= '0;
      len_q     <= '0;
      tag_line  <= '0;
      ain_q     <= '0;
      wsel_q    <= 1'b0;
      weight_en <= '0;
      wt_ready  <= 1'b0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      weight_en <= '0;
      done      <= 1'b0;
      wsel_q    <= 1'b0;
      ain_q     <= '0;
      tag_line  <= {tag_line[TAG_D-2:0], 1'b0};
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_W;
            len_q    <= cfg_len;
            wbeat    <= '0;
            vcnt     <= '0;
            wt_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD_W: begin
          if (wt_valid && wt_ready) begin
            ain_q     <= wt_data;
            wsel_q    <= 1'b1;
            weight_en <= ROW_MSB >> wbeat;
            if (wbeat == WB_W'(ROWS - 1)) begin
              wt_ready <= 1'b0;
              if (len_q == '0) begin
                state <= S_DRAIN;
              end else begin
                state     <= S_STREAM;
                act_ready <= 1'b1;
              end
            end else begin
              wbeat <= wbeat + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (act_valid && act_ready) begin
            ain_q    <= act_data;
            tag_line <= {tag_line[TAG_D-2:0], 1'b1};
            vcnt     <= vcnt_nxt;
            if (vcnt_nxt == len_q) begin
              act_ready <= 1'b0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (tag_line == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SKEW_GEN_EN
  logic [COLS*int_bits-1:0] skew_in;
  logic [COLS*int_bits-1:0] skewed;

  // Weight rows bypass the skew so each row lands in one cycle.
  assign skew_in = wsel_q ? '0 : ain_q;

  for (genvar c = 0; c < COLS; c++) begin : g_skew
    skew_buf #(
      .W     (int_bits),
      .DEPTH (c)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .din   (skew_in[c*int_bits +: int_bits]),
      .dout  (skewed[c*int_bits +: int_bits])
    );
    assign out_valid[c] = tag_line[ROWS + c];
  end

  assign array_in = wsel_q ? ain_q : skewed;
`else
  assign array_in  = ain_q;
  assign out_valid = {COLS{tag_line[ROWS]}};
`endif

endmodule
